// File: rtl/adder_share_if.sv
// Handshake and shared-adder bundle for adder_share_arb.
// slave = arbiter side, master = requesters / adder / consumer side.
interface adder_share_if #(
  parameter int W = 5
);
  logic          req0_valid;
  logic          req1_valid;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;
  logic          req0_ready;
  logic          req1_ready;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic [W:0]    add_sum;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W:0]    rsp_sum;
  logic [15:0]   err_cnt;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  add_sum, rsp_ready,
    output req0_ready, req1_ready, add_a, add_b,
    output rsp_valid, rsp_id, rsp_sum, err_cnt
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output add_sum, rsp_ready,
    input  req0_ready, req1_ready, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_sum, err_cnt
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one approximate adder between two requesters.
// Optional error monitor enabled by defining ADDER_SHARE_ERR_MON_EN.
//
// state | meaning
// IDLE  | waiting for a request, ready asserted for the granted requester
// BUSY  | operands held on add_a/add_b, counting adder latency
// RESP  | rsp_valid high, waiting for rsp_ready
module adder_share_arb #(
  parameter int W       = 5,
  parameter int ADD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  adder_share_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [1:0] LAT_C = 2'(ADD_LAT);

  state_t         state, state_nxt;
  logic [W-1:0]   add_a_q, add_b_q;
  logic [W:0]     rsp_sum_q;
  logic           rsp_id_q, id_q, ptr_q;
  logic [1:0]     cnt_q;
  logic           gnt_v, gnt_id, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ready is gated by rst because state already reads IDLE during reset.
  always_comb begin
    state_nxt = state;
    gnt_v     = 1'b0;
    gnt_id    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (bus.req0_valid && bus.req1_valid) gnt_id = ptr_q;
          else                                  gnt_id = bus.req1_valid;
          gnt_v = bus.req0_valid | bus.req1_valid;
          if (gnt_v) state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAT_C) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      id_q      <= 1'b0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      rsp_sum_q <= '0;
      rsp_id_q  <= 1'b0;
    end else begin
      if (gnt_v) begin
        add_a_q <= gnt_id ? bus.req1_a : bus.req0_a;
        add_b_q <= gnt_id ? bus.req1_b : bus.req0_b;
        id_q    <= gnt_id;
        ptr_q   <= ~gnt_id;
        cnt_q   <= '0;
      end else if (state == BUSY) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (capture) begin
        rsp_sum_q <= bus.add_sum;
        rsp_id_q  <= id_q;
      end
    end
  end

  assign bus.req0_ready = gnt_v & ~gnt_id;
  assign bus.req1_ready = gnt_v & gnt_id;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = rsp_sum_q;

`ifdef ADDER_SHARE_ERR_MON_EN
  logic [W:0]  exact_sum;
  logic [15:0] err_q;

  assign exact_sum = {1'b0, add_a_q} + {1'b0, add_b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else if (capture && (bus.add_sum != exact_sum) && (err_q != 16'hFFFF))
      err_q <= err_q + 16'd1;
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = '0;
`endif
endmodule
